// File: rtl/seq_booth_mul.sv
// -----------------------------------------------------------------------------
// seq_booth_mul
//   Multi-cycle signed multiplier using radix-2 Booth recoding. It feeds the
//   7-segment sign/tens/ones display decoder in place of a combinational a*b.
//   The product register holds its value between operations, so the display
//   never sees intermediate partial products.
//
// Parameters
//   W        operand width (two's complement); product is 2*W bits
//
// Ports
//   clk      in   1     system clock, all state changes on posedge
//   rst      in   1     synchronous reset, active-high, beats start
//   start    in   1     one-cycle request; a and b sampled on the same edge
//   a        in   W     signed multiplicand
//   b        in   W     signed multiplier
//   busy     out  1     high while the Booth steps are running
//   done     out  1     one-cycle pulse; product valid from this cycle on
//   product  out  2W    signed a*b, held until the next result is written
//
// Handshake
//   start is accepted only when busy is low (IDLE, or the DONE cycle itself,
//   which allows back-to-back operations). A start seen while busy is high is
//   dropped and a/b are not re-sampled. done pulses for exactly one cycle per
//   accepted start, never in the same cycle as busy; a reset before done
//   aborts the operation and produces no done.
//
// Configuration macro
//   MUL_ZERO_SKIP_EN  when defined, a start with a==0 or b==0 jumps straight
//                     to DONE with product=0 (busy never raised). Products are
//                     identical in both builds; only latency differs.
// -----------------------------------------------------------------------------
module seq_booth_mul #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   product
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    // Accumulator and multiplicand carry one extra bit so that M = -2^(W-1)
    // (and A - M) never overflow.
    logic [W:0]    acc;
    logic [W:0]    mcand;
    logic [W-1:0]  mplier;
    logic          q_1;
    logic [CW-1:0] count;

    logic          accept;
    logic          zero_op;
    logic          last_step;
    logic [W:0]    step_sum;
    logic [W:0]    acc_sh;
    logic [W-1:0]  mplier_sh;
    logic          q1_sh;

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_step = (state == RUN) && (count == CW'(1));

`ifdef MUL_ZERO_SKIP_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    // One Booth step: add/subtract M on the {Q[0], q_1} pair, then an
    // arithmetic right shift of the concatenation {A, Q, q_1}.
    always_comb begin
        step_sum = acc;
        case ({mplier[0], q_1})
            2'b01:   step_sum = acc + mcand;
            2'b10:   step_sum = acc - mcand;
            default: step_sum = acc;
        endcase
    end

    assign acc_sh    = {step_sum[W], step_sum[W:1]};
    assign mplier_sh = {step_sum[0], mplier[W-1:1]};
    assign q1_sh     = mplier[0];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = zero_op ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nx = zero_op ? DONE : RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            q_1     <= 1'b0;
            count   <= '0;
            product <= '0;
        end else if (accept) begin
            acc    <= '0;
            mcand  <= {a[W-1], a};
            mplier <= b;
            q_1    <= 1'b0;
            count  <= CW'(W);
            if (zero_op) begin
                product <= '0;
            end
        end else if (state == RUN) begin
            acc    <= acc_sh;
            mplier <= mplier_sh;
            q_1    <= q1_sh;
            count  <= count - CW'(1);
            // The final step's shifted value is written directly, so product
            // only changes on the edge that enters DONE.
            if (last_step) begin
                product <= {acc_sh[W-1:0], mplier_sh};
            end
        end
    end

endmodule
